// File: rtl/uart_rx_feeder.sv
// uart_rx_feeder: buffers host characters and meters them into the
// SoC console input as single-cycle strobes separated by an idle gap.
module uart_rx_feeder #(
  parameter int DEPTH = 16,
  parameter int GAP   = 8,
  parameter int START = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_chr,
  input  logic                     flush,
  input  logic                     enable,
  output logic                     uart_rx_vld,
  output logic [7:0]               uart_rx_chr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              sent
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state;
  logic [31:0]   cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic          full;
  logic          push;
  logic          pop;

  assign full        = (level == (AW+1)'(DEPTH));
  assign in_ready    = ~full & (state != S_INIT);
  assign uart_rx_vld = (state == S_SEND);

  // Flush wins over any push; a pop only happens on IDLE->SEND.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = (state == S_IDLE) & enable
              & (level != '0) & ~flush;

  // FIFO storage, cleared on reset so stale bytes never leak out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (push) begin
      mem[wr] <= in_chr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (push)
        wr <= wr + 1'b1;
      if (pop)
        rd <= rd + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Injection sequencer: start delay, then strobe/gap/idle per byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_INIT;
      cnt         <= 32'(START);
      uart_rx_chr <= 8'h00;
      sent        <= 32'd0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (cnt == 32'd0)
            state <= S_IDLE;
          else
            cnt <= cnt - 32'd1;
        end
        S_IDLE: begin
          if (pop) begin
            state       <= S_SEND;
            uart_rx_chr <= mem[rd];
            sent        <= sent + 32'd1;
          end
        end
        S_SEND: begin
          if (GAP > 0) begin
            state <= S_GAP;
            cnt   <= 32'(GAP - 1);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (cnt == 32'd0)
            state <= S_IDLE;
          else
            cnt <= cnt - 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_feeder.sv
// tb_uart_rx_feeder: directed and random stimulus against a
// queue-based timing model of the console feeder.
module tb_uart_rx_feeder;

  localparam int DEPTH = 16;
  localparam int GAP   = 8;
  localparam int START = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_chr = 8'h00;
  logic        flush = 1'b0;
  logic        enable = 1'b0;
  logic        in_ready;
  logic        uart_rx_vld;
  logic [7:0]  uart_rx_chr;
  logic [4:0]  level;
  logic [31:0] sent;

  uart_rx_feeder #(
    .DEPTH(DEPTH),
    .GAP(GAP),
    .START(START)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_chr(in_chr),
    .flush(flush),
    .enable(enable),
    .uart_rx_vld(uart_rx_vld),
    .uart_rx_chr(uart_rx_chr),
    .level(level),
    .sent(sent)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  q[$];
  int          m_init;
  int          m_busy;
  logic [7:0]  m_chr;
  logic [31:0] m_sent;

  int          stb_cyc[$];
  logic [7:0]  stb_chr[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_init = START + 1;
    m_busy = 0;
    m_chr  = 8'h00;
    m_sent = 32'd0;
  endtask

  function automatic bit m_ready();
    return (m_init == 0) && (q.size() < DEPTH);
  endfunction

  task automatic compare_all();
    bit exp_vld;
    exp_vld = (m_init == 0) && (m_busy == GAP + 1);
    check("vld", 32'(uart_rx_vld), 32'(exp_vld));
    check("chr", 32'(uart_rx_chr), 32'(m_chr));
    check("level", 32'(level), 32'(q.size()));
    check("ready", 32'(in_ready), 32'(m_ready()));
    check("sent", sent, m_sent);
  endtask

  task automatic tick(input logic v, input logic [7:0] c,
                      input logic f, input logic e);
    bit idle;
    bit push;
    bit pop;
    in_valid = v;
    in_chr   = c;
    flush    = f;
    enable   = e;
    idle = (m_init == 0) && (m_busy == 0);
    push = v && m_ready() && !f;
    pop  = idle && e && (q.size() > 0) && !f;
    @(posedge clock);
    #1;
    cyc++;
    if (m_init > 0)
      m_init--;
    else if (m_busy > 0)
      m_busy--;
    if (f) begin
      q.delete();
    end else begin
      if (pop) begin
        m_chr = q.pop_front();
        m_sent++;
        m_busy = GAP + 1;
      end
      if (push)
        q.push_back(c);
    end
    compare_all();
    if (uart_rx_vld) begin
      stb_cyc.push_back(cyc);
      stb_chr.push_back(uart_rx_chr);
    end
  endtask

  task automatic idle_for(input int n, input logic e);
    for (int i = 0; i < n; i++)
      tick(1'b0, 8'h00, 1'b0, e);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (stb_cyc.size() < n && k < budget) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      k++;
    end
    check("strobe_timeout", 32'(stb_cyc.size() >= n), 32'd1);
  endtask

  task automatic do_reset_release();
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  logic [7:0]  hello [5];
  logic [31:0] s0;
  logic [7:0]  saved;
  int          tin;
  int          traise;

  initial begin
    hello[0] = 8'h48;
    hello[1] = 8'h45;
    hello[2] = 8'h4C;
    hello[3] = 8'h4C;
    hello[4] = 8'h4F;
    m_reset();
    #12;
    compare_all();
    do_reset_release();

    // pushes attempted during the start delay are refused
    for (int i = 0; i < START; i++) begin
      tick(1'b1, 8'($urandom), 1'b0, 1'b1);
      check("init_ready", 32'(in_ready), 32'd0);
    end
    tick(1'b1, 8'h99, 1'b0, 1'b1);
    check("init_done_ready", 32'(in_ready), 32'd1);
    check("init_level", 32'(level), 32'd0);

    // single byte latency
    stb_cyc.delete();
    stb_chr.delete();
    tin = cyc;
    tick(1'b1, 8'h41, 1'b0, 1'b1);
    idle_for(12, 1'b1);
    check("one_count", 32'(stb_cyc.size()), 32'd1);
    if (stb_cyc.size() > 0) begin
      check("one_lat", 32'(stb_cyc[0]), 32'(tin + 2));
      check("one_chr", 32'(stb_chr[0]), 32'h41);
    end
    check("one_hold", 32'(uart_rx_chr), 32'h41);

    // HELLO back-to-back
    stb_cyc.delete();
    stb_chr.delete();
    s0 = sent;
    for (int i = 0; i < 5; i++)
      tick(1'b1, hello[i], 1'b0, 1'b1);
    idle_for(60, 1'b1);
    check("hello_count", 32'(stb_cyc.size()), 32'd5);
    for (int i = 0; i < stb_cyc.size() && i < 5; i++) begin
      check("hello_chr", 32'(stb_chr[i]), 32'(hello[i]));
      if (i > 0)
        check("hello_gap",
              32'(stb_cyc[i] - stb_cyc[i-1]), 32'(GAP + 2));
    end
    check("hello_sent", sent - s0, 32'd5);

    // overfill while disabled
    for (int i = 0; i < DEPTH + 1; i++)
      tick(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_ready", 32'(in_ready), 32'd0);
    stb_cyc.delete();
    stb_chr.delete();
    for (int i = 0; i < 3; i++)
      tick(1'b1, 8'h7A, 1'b0, 1'b1);
    check("full_strobe", 32'(stb_cyc.size()), 32'd1);
    check("full_refill", 32'(level), 32'(DEPTH));
    idle_for((DEPTH + 1) * (GAP + 2) + 4, 1'b1);
    check("full_drain", 32'(level), 32'd0);

    // enable dropped during a gap
    stb_cyc.delete();
    stb_chr.delete();
    for (int i = 0; i < 4; i++)
      tick(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
    wait_strobes(2, 40);
    idle_for(3, 1'b1);
    idle_for(30, 1'b0);
    check("park_count", 32'(stb_cyc.size()), 32'd2);
    traise = cyc;
    wait_strobes(3, 10);
    if (stb_cyc.size() > 2)
      check("park_resume",
            32'(stb_cyc[2] - traise <= 2), 32'd1);
    idle_for(30, 1'b1);

    // flush during a gap
    for (int i = 0; i < 6; i++)
      tick(1'b1, 8'(8'h50 + i), 1'b0, 1'b1);
    check("flush_pre", 32'(level), 32'd5);
    saved = uart_rx_chr;
    stb_cyc.delete();
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    check("flush_level", 32'(level), 32'd0);
    idle_for(30, 1'b1);
    check("flush_nostrobe", 32'(stb_cyc.size()), 32'd0);
    check("flush_chr", 32'(uart_rx_chr), 32'(saved));

    // reset while a strobe is on the wire
    stb_cyc.delete();
    tick(1'b1, 8'h5A, 1'b0, 1'b1);
    wait_strobes(1, 5);
    #2;
    reset = 1'b1;
    #1;
    check("rst_vld", 32'(uart_rx_vld), 32'd0);
    check("rst_sent", sent, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_chr", 32'(uart_rx_chr), 32'd0);
    do_reset_release();
    for (int i = 0; i < START; i++) begin
      tick(1'b1, 8'h11, 1'b0, 1'b1);
      check("rst_init_ready", 32'(in_ready), 32'd0);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 40,
           8'($urandom),
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 80);
      if (i == 1500) begin
        #3;
        reset = 1'b1;
        #1;
        check("rnd_rst_vld", 32'(uart_rx_vld), 32'd0);
        do_reset_release();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
